// File: rtl/cnt_seq_checker_if.sv
// Bundles the sample stream and status outputs of the counter sequence checker.
// Latency: n/a (wiring only).
// Backpressure: none; the checker accepts a sample on every cycle valid_i is high.
//
// Ports (master = stream source / observer, slave = checker):
//   cnt_i, valid_i, clr_i            : source -> checker
//   locked_o, err_o, err_cnt_o,
//   exp_o, state_o                   : checker -> observer
interface cnt_seq_checker_if #(
  parameter int WIDTH = 8,
  parameter int ERR_W = 8
);
  logic [WIDTH-1:0] cnt_i;
  logic             valid_i;
  logic             clr_i;
  logic             locked_o;
  logic             err_o;
  logic [ERR_W-1:0] err_cnt_o;
  logic [WIDTH-1:0] exp_o;
  logic [1:0]       state_o;

  modport master (
    output cnt_i, valid_i, clr_i,
    input  locked_o, err_o, err_cnt_o, exp_o, state_o
  );

  modport slave (
    input  cnt_i, valid_i, clr_i,
    output locked_o, err_o, err_cnt_o, exp_o, state_o
  );
endinterface

// File: rtl/cnt_seq_checker.sv
// Checks a stepped counter stream: locks after LOCK_CNT good steps, then flags each out-of-sequence sample.
// Latency: 1 cycle; all outputs registered, response to the sample on edge N is visible after edge N.
// Backpressure: none; samples are taken only when valid_i=1, idle cycles change nothing.
//
// Ports: clk, reset (async active-low), bus (cnt_seq_checker_if.slave) carrying
//   cnt_i/valid_i/clr_i in and locked_o/err_o/err_cnt_o/exp_o/state_o out.
module cnt_seq_checker #(
  parameter int WIDTH    = 8,
  parameter int STEP     = 2,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  cnt_seq_checker_if.slave   bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACQ    = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [3:0]       LOCK_W  = 4'(LOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  // exp_q holds prev+STEP directly rather than prev; it is loaded whenever
  // prev would be, so the match compare is a plain equality. Modular wrap
  // falls out of the WIDTH-bit add.
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [3:0]       run_q, run_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic             match;
  logic [3:0]       run_inc;
  logic [WIDTH-1:0] next_exp;

  assign match    = (bus.cnt_i == exp_q);
  assign run_inc  = run_q + 4'd1;
  assign next_exp = bus.cnt_i + STEP_W;

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    run_d     = run_q;
    locked_d  = locked_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;

    case (state_q)
      ST_IDLE: begin
        // First sample only seeds the expectation; nothing to compare yet.
        if (bus.valid_i) begin
          exp_d   = next_exp;
          run_d   = 4'd0;
          state_d = ST_ACQ;
        end
      end
      ST_ACQ: begin
        if (bus.valid_i) begin
          exp_d = next_exp;
          if (match) begin
            run_d = run_inc;
            if (run_inc == LOCK_W) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            // Resync on the new value without reporting an error.
            run_d = 4'd0;
          end
        end
      end
      ST_LOCKED: begin
        if (bus.valid_i) begin
          exp_d = next_exp;
          if (!match) begin
            err_d    = 1'b1;
            run_d    = 4'd0;
            state_d  = ST_ACQ;
            locked_d = 1'b0;
          end
        end
      end
      default: begin
        // Encoding 3 is unreachable in normal operation; recover to IDLE.
        state_d  = ST_IDLE;
        run_d    = 4'd0;
        locked_d = 1'b0;
      end
    endcase

    // Clear wins over a coincident increment; err_o itself is unaffected.
    if (bus.clr_i) begin
      err_cnt_d = '0;
    end else if (err_d && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      exp_q     <= '0;
      run_q     <= 4'd0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      run_q     <= run_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.state_o   = state_q;
  assign bus.exp_o     = exp_q;
  assign bus.locked_o  = locked_q;
  assign bus.err_o     = err_q;
  assign bus.err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Directed bench for cnt_seq_checker (WIDTH=8, STEP=2, LOCK_CNT=4, ERR_W=8).
// Latency: checks sampled 1 time unit after the rising edge that took the sample.
// Backpressure: none; inputs driven on the falling edge.
module tb_cnt_seq_checker;

  logic clk;
  logic reset;

  cnt_seq_checker_if #(.WIDTH(8), .ERR_W(8)) bus ();

  cnt_seq_checker #(
    .WIDTH(8), .STEP(2), .LOCK_CNT(4), .ERR_W(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;
  logic [7:0] pv;       // last sample value sent
  int exp_errs;         // expected saturating error count

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
  endtask

  // Present one valid sample, let the edge take it, return just after the edge.
  task automatic send(input logic [7:0] v, input logic clr);
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.cnt_i   = v;
    bus.clr_i   = clr;
    pv          = v;
    @(posedge clk);
    #1;
  endtask

  // One cycle with valid_i low and a junk value on cnt_i.
  task automatic idle(input logic [7:0] junk);
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.cnt_i   = junk;
    bus.clr_i   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // From ACQ with last sample pv, four correct steps reach LOCKED.
  task automatic relock();
    for (int k = 0; k < 4; k++) send(pv + 8'd2, 1'b0);
  endtask

  // Mismatch while locked: odd offset can never equal pv+2.
  task automatic mismatch(input logic clr);
    send(pv + 8'd5, clr);
    if (clr) exp_errs = 0;
    else if (exp_errs < 255) exp_errs++;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; exp_errs = 0; pv = 8'd0;
    reset = 1'b0;
    bus.valid_i = 1'b0; bus.cnt_i = 8'd0; bus.clr_i = 1'b0;
    #12;
    check("rst_state",  32'(bus.state_o),   32'd0);
    check("rst_locked", 32'(bus.locked_o),  32'd0);
    check("rst_err",    32'(bus.err_o),     32'd0);
    check("rst_errcnt", 32'(bus.err_cnt_o), 32'd0);
    check("rst_exp",    32'(bus.exp_o),     32'd0);
    @(negedge clk); reset = 1'b1;

    // Acquisition 1,3,5,7,9
    send(8'd1, 1'b0);
    check("acq_state1", 32'(bus.state_o), 32'd1);
    check("acq_exp1",   32'(bus.exp_o),   32'd3);
    send(8'd3, 1'b0); send(8'd5, 1'b0); send(8'd7, 1'b0);
    check("acq_not_locked", 32'(bus.locked_o), 32'd0);
    send(8'd9, 1'b0);
    check("lock_locked", 32'(bus.locked_o),  32'd1);
    check("lock_state",  32'(bus.state_o),   32'd2);
    check("lock_exp",    32'(bus.exp_o),     32'd11);
    check("lock_errcnt", 32'(bus.err_cnt_o), 32'd0);

    // Gaps ignored: 11, X, X, 13
    send(8'd11, 1'b0);
    idle(8'd99);
    check("gap_err",   32'(bus.err_o),   32'd0);
    idle(8'd200);
    check("gap_state", 32'(bus.state_o), 32'd2);
    check("gap_exp",   32'(bus.exp_o),   32'd13);
    send(8'd13, 1'b0);
    check("gap_end_err",   32'(bus.err_o),   32'd0);
    check("gap_end_state", 32'(bus.state_o), 32'd2);

    // Inject 20 while locked
    send(8'd20, 1'b0);
    exp_errs = 1;
    check("inj_err",    32'(bus.err_o),     32'd1);
    check("inj_errcnt", 32'(bus.err_cnt_o), 32'd1);
    check("inj_locked", 32'(bus.locked_o),  32'd0);
    check("inj_state",  32'(bus.state_o),   32'd1);
    check("inj_exp",    32'(bus.exp_o),     32'd22);
    send(8'd22, 1'b0);
    check("inj_pulse_1cyc", 32'(bus.err_o), 32'd0);
    send(8'd24, 1'b0); send(8'd26, 1'b0);
    check("relock_pending", 32'(bus.locked_o), 32'd0);
    send(8'd28, 1'b0);
    check("relock_locked", 32'(bus.locked_o), 32'd1);

    // Reach 249 locked, then walk through the wrap
    send(8'd241, 1'b0);
    exp_errs = 2;
    check("pre_wrap_err", 32'(bus.err_o), 32'd1);
    relock();
    check("pre_wrap_locked", 32'(bus.locked_o), 32'd1);
    begin
      logic [7:0] wrap_vals [5];
      wrap_vals = '{8'd251, 8'd253, 8'd255, 8'd1, 8'd3};
      for (int i = 0; i < 5; i++) begin
        send(wrap_vals[i], 1'b0);
        check("wrap_err",   32'(bus.err_o),   32'd0);
        check("wrap_state", 32'(bus.state_o), 32'd2);
      end
    end
    check("wrap_exp", 32'(bus.exp_o), 32'd5);

    // Back-to-back mismatches: only the first pulses
    send(8'd50, 1'b0);
    exp_errs = 3;
    check("b2b_first_err", 32'(bus.err_o), 32'd1);
    send(8'd60, 1'b0);
    check("b2b_second_err",   32'(bus.err_o),     32'd0);
    check("b2b_second_state", 32'(bus.state_o),   32'd1);
    check("b2b_errcnt",       32'(bus.err_cnt_o), 32'd3);

    // Drive the error counter to saturation
    for (int i = 0; i < 252; i++) begin
      relock();
      mismatch(1'b0);
    end
    check("sat_reach", 32'(bus.err_cnt_o), 32'(exp_errs));
    check("sat_value", 32'(bus.err_cnt_o), 32'd255);
    relock();
    mismatch(1'b0);
    check("sat_err_pulse", 32'(bus.err_o),     32'd1);
    check("sat_hold",      32'(bus.err_cnt_o), 32'd255);

    // Clear coincident with a mismatch
    relock();
    mismatch(1'b1);
    check("clr_err_pulse", 32'(bus.err_o),     32'd1);
    check("clr_errcnt",    32'(bus.err_cnt_o), 32'd0);
    check("clr_state",     32'(bus.state_o),   32'd1);

    // One more error, relock, then async reset between edges
    relock();
    mismatch(1'b0);
    relock();
    check("pre_rst_errcnt", 32'(bus.err_cnt_o), 32'd1);
    check("pre_rst_locked", 32'(bus.locked_o),  32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_state",  32'(bus.state_o),   32'd0);
    check("async_locked", 32'(bus.locked_o),  32'd0);
    check("async_errcnt", 32'(bus.err_cnt_o), 32'd0);
    check("async_exp",    32'(bus.exp_o),     32'd0);
    @(negedge clk);
    bus.valid_i = 1'b0;
    reset = 1'b1;
    send(8'd7, 1'b0);
    check("post_rst_state", 32'(bus.state_o), 32'd1);
    check("post_rst_exp",   32'(bus.exp_o),   32'd9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
